// File: rtl/cu_write_command_arbiter_control_pkg.sv
// cu_write_command_arbiter_control_pkg: shared types and sizing for the CU write command arbiter
package cu_write_command_arbiter_control_pkg;
  localparam int WRITE_ARB_NUM_REQUESTORS = 4;
  localparam int WRITE_ARB_MAX_OUTSTANDING = 16;
  localparam int ARRAY_SIZE_BITS = 8;
  localparam int CU_ID_BITS = 4;
  localparam int ADDRESS_BITS = 32;
  localparam int DATA_BITS = 32;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} cu_write_arb_state_t;
  typedef struct packed {
    logic [CU_ID_BITS-1:0] cu_id;
    logic [ADDRESS_BITS-1:0] address;
  } command_t;
  typedef struct packed {
    logic valid;
    command_t cmd;
  } command_buffer_line_t;
  typedef struct packed {
    logic valid;
    logic [DATA_BITS-1:0] data;
  } read_write_data_line_t;
  typedef struct packed {
    logic alm_full;
  } buffer_status_t;
  typedef struct packed {
    logic [CU_ID_BITS-1:0] cu_id;
  } response_t;
  typedef struct packed {
    logic valid;
    response_t cmd;
  } response_buffer_line_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/cu_write_command_arbiter_control_round_robin_arbiter.sv
// cu_write_command_arbiter_control_round_robin_arbiter: one-hot winner at or after the pointer
module cu_write_command_arbiter_control_round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         request,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         winner,
  output logic [$clog2(N)-1:0] index
);
  localparam int IW = $clog2(N);
  logic found;
  always_comb begin
    winner = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && request[(int'(pointer) + i) % N]) begin
        found = 1'b1;
        winner[(int'(pointer) + i) % N] = 1'b1;
        index = IW'((int'(pointer) + i) % N);
      end
    end
  end
endmodule

// File: rtl/cu_write_command_arbiter_control.sv
// cu_write_command_arbiter_control: round-robin sharing of the write command buffer with credit throttle and drain
module cu_write_command_arbiter_control
  import cu_write_command_arbiter_control_pkg::*;
#(
  parameter int NUM_REQUESTORS  = WRITE_ARB_NUM_REQUESTORS,
  parameter int MAX_OUTSTANDING = WRITE_ARB_MAX_OUTSTANDING
) (
  input  logic                             clock,
  input  logic                             rstn,
  input  logic                             enabled_in,
  input  logic [NUM_REQUESTORS-1:0]        request_in,
  input  command_buffer_line_t             command_in [NUM_REQUESTORS],
  input  read_write_data_line_t            write_data_0_in [NUM_REQUESTORS],
  input  read_write_data_line_t            write_data_1_in [NUM_REQUESTORS],
  input  buffer_status_t                   write_command_buffer_status,
  input  response_buffer_line_t            write_response_in,
  output logic [NUM_REQUESTORS-1:0]        grant_out,
  output command_buffer_line_t             write_command_out,
  output read_write_data_line_t            write_data_0_out,
  output read_write_data_line_t            write_data_1_out,
  output logic [ARRAY_SIZE_BITS-1:0]       write_job_counter_done [NUM_REQUESTORS],
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_count_out,
  output logic                             idle_out,
  output logic                             error_out
);
  localparam int IW = $clog2(NUM_REQUESTORS);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  cu_write_arb_state_t state, state_next;
  logic [IW-1:0] pointer, win_index;
  logic [NUM_REQUESTORS-1:0] win;
  logic [OW-1:0] outstanding, outstanding_next;
  logic issue, resp_empty, resp_bad, retire;
  cu_write_command_arbiter_control_round_robin_arbiter #(.N(NUM_REQUESTORS)) u_arb (
    .request(request_in),
    .pointer(pointer),
    .winner(win),
    .index(win_index)
  );
  always_comb begin
    issue = state == ACTIVE && enabled_in && |request_in && !write_command_buffer_status.alm_full
            && outstanding < OW'(MAX_OUTSTANDING);
    resp_empty = write_response_in.valid && outstanding == '0;
    resp_bad = write_response_in.valid && int'(write_response_in.cmd.cu_id) >= NUM_REQUESTORS;
    // a response with nothing in flight must not underflow the credit counter
    retire = write_response_in.valid && !resp_empty;
    outstanding_next = outstanding + OW'(issue) - OW'(retire);
    state_next = state == IDLE ? (enabled_in ? ACTIVE : IDLE)
               : enabled_in ? ACTIVE
               : state == ACTIVE ? DRAIN
               : outstanding == '0 ? IDLE : DRAIN;
  end
  always_ff @(posedge clock) begin
    if (rstn) begin
      state <= IDLE;
      pointer <= '0;
      outstanding <= '0;
      error_out <= 1'b0;
      grant_out <= '0;
      write_command_out <= '0;
      write_data_0_out <= '0;
      write_data_1_out <= '0;
      for (int i = 0; i < NUM_REQUESTORS; i++) write_job_counter_done[i] <= '0;
    end else begin
      state <= state_next;
      outstanding <= outstanding_next;
      error_out <= error_out | resp_empty | resp_bad;
      grant_out <= issue ? win : '0;
      write_command_out <= issue ? command_in[win_index] : '0;
      write_data_0_out <= issue ? write_data_0_in[win_index] : '0;
      write_data_1_out <= issue ? write_data_1_in[win_index] : '0;
      if (issue) pointer <= IW'(wrap_inc(int'(win_index), NUM_REQUESTORS));
      if (write_response_in.valid && !resp_bad)
        write_job_counter_done[write_response_in.cmd.cu_id[IW-1:0]] <=
          write_job_counter_done[write_response_in.cmd.cu_id[IW-1:0]] + ARRAY_SIZE_BITS'(1);
    end
  end
  assign idle_out = state == IDLE;
  assign outstanding_count_out = outstanding;
endmodule

// File: tb/tb_cu_write_command_arbiter_control.sv
// tb_cu_write_command_arbiter_control: directed bench with a cycle-level reference model
module tb_cu_write_command_arbiter_control;
  import cu_write_command_arbiter_control_pkg::*;
  logic clk, rstn, enabled_in;
  logic [3:0] request_in;
  command_buffer_line_t command_in [4];
  read_write_data_line_t write_data_0_in [4];
  read_write_data_line_t write_data_1_in [4];
  buffer_status_t status;
  response_buffer_line_t resp;
  logic [3:0] grant_out;
  command_buffer_line_t write_command_out;
  read_write_data_line_t write_data_0_out, write_data_1_out;
  logic [7:0] done [4];
  logic [4:0] outstanding_count_out;
  logic idle_out, error_out;
  int vectors = 0;
  int miscompares = 0;

  cu_write_command_arbiter_control dut (
    .clock(clk), .rstn(rstn), .enabled_in(enabled_in), .request_in(request_in),
    .command_in(command_in), .write_data_0_in(write_data_0_in), .write_data_1_in(write_data_1_in),
    .write_command_buffer_status(status), .write_response_in(resp), .grant_out(grant_out),
    .write_command_out(write_command_out), .write_data_0_out(write_data_0_out),
    .write_data_1_out(write_data_1_out), .write_job_counter_done(done),
    .outstanding_count_out(outstanding_count_out), .idle_out(idle_out), .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // reference model: mode 0=idle 1=arbitrating 2=draining
  int m_state, m_ptr, m_out, old_out, w, c;
  int m_done [4];
  bit m_err, can, started;
  logic [3:0] e_grant;
  command_buffer_line_t e_cmd;
  read_write_data_line_t e_d0, e_d1;

  always @(posedge clk) begin
    if (rstn) begin
      m_state = 0; m_ptr = 0; m_out = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_done[i] = 0;
      e_grant = '0; e_cmd = '0; e_d0 = '0; e_d1 = '0;
    end else begin
      old_out = m_out;
      can = m_state == 1 && enabled_in && request_in != 0 && !status.alm_full && m_out < 16;
      e_grant = '0; e_cmd = '0; e_d0 = '0; e_d1 = '0;
      if (can) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (w < 0 && request_in[c]) w = c;
        end
        e_grant[w] = 1'b1;
        e_cmd = command_in[w]; e_d0 = write_data_0_in[w]; e_d1 = write_data_1_in[w];
        m_ptr = (w + 1) % 4;
      end
      if (resp.valid) begin
        if (old_out == 0) m_err = 1; else m_out = m_out - 1;
        if (resp.cmd.cu_id >= 4) m_err = 1;
        else m_done[resp.cmd.cu_id] = (m_done[resp.cmd.cu_id] + 1) % 256;
      end
      if (can) m_out = m_out + 1;
      if (m_state == 0) m_state = enabled_in ? 1 : 0;
      else if (enabled_in) m_state = 1;
      else m_state = (m_state == 1) ? 2 : (old_out == 0 ? 0 : 2);
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("grant", grant_out, e_grant);
      chk("command", write_command_out, e_cmd);
      chk("data0", write_data_0_out, e_d0);
      chk("data1", write_data_1_out, e_d1);
      chk("outstanding", outstanding_count_out, m_out);
      chk("idle", idle_out, m_state == 0);
      chk("error", error_out, m_err);
      for (int i = 0; i < 4; i++) chk("done", done[i], m_done[i] % 256);
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      command_in[i].valid = 1'b1;
      command_in[i].cmd.cu_id = 4'(i);
      command_in[i].cmd.address = 32'h1000 + 32'(i);
      write_data_0_in[i].valid = 1'b1;
      write_data_0_in[i].data = 32'hA0 + 32'(i);
      write_data_1_in[i].valid = 1'b1;
      write_data_1_in[i].data = 32'hB0 + 32'(i);
    end
    rstn = 1'b1; enabled_in = 1'b0; request_in = '0; status = '0; resp = '0;
    step(2);
    chk("rst_idle", idle_out, 1);
    chk("rst_grant", grant_out, 0);
    chk("rst_outstanding", outstanding_count_out, 0);
    chk("rst_error", error_out, 0);
    // single requester held for three arbitration cycles
    rstn = 1'b0; enabled_in = 1'b1; request_in = 4'b0001;
    step(1);
    chk("t1_active", idle_out, 0);
    chk("t1_first_grant", grant_out, 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t1_grant", grant_out, 4'b0001);
    end
    chk("t1_outstanding", outstanding_count_out, 3);
    request_in = '0;
    step(1);
    chk("t1_no_grant", grant_out, 0);
    // all four requesting from a fresh pointer
    rstn = 1'b1;
    step(1);
    chk("t2_rst", outstanding_count_out, 0);
    rstn = 1'b0; request_in = 4'b1111;
    command_in[3].cmd.address = 32'hDEAD_0003;
    step(1);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t2_rr", grant_out, 4'b0001 << (k % 4));
    end
    request_in = '0;
    // almost-full throttle, pointer at 1
    status.alm_full = 1'b1; request_in = 4'b1100;
    step(1);
    chk("t3_full0", grant_out, 0);
    step(1);
    chk("t3_full1", grant_out, 0);
    status.alm_full = 1'b0;
    step(1);
    chk("t3_resume", grant_out, 4'b0100);
    request_in = '0;
    step(1);
    // credit limit
    request_in = 4'b0001;
    step(10);
    chk("t4_at_limit", outstanding_count_out, 16);
    step(2);
    chk("t4_blocked", grant_out, 0);
    chk("t4_held", outstanding_count_out, 16);
    resp.valid = 1'b1; resp.cmd.cu_id = 4'd0;
    step(1);
    chk("t4_retire", outstanding_count_out, 15);
    chk("t4_retire_grant", grant_out, 0);
    resp.valid = 1'b0;
    step(1);
    chk("t4_regrant", grant_out, 4'b0001);
    chk("t4_refill", outstanding_count_out, 16);
    resp.valid = 1'b1;
    step(2);
    chk("t4_same_cycle_grant", grant_out, 4'b0001);
    chk("t4_same_cycle_count", outstanding_count_out, 15);
    resp.valid = 1'b0; request_in = '0;
    step(1);
    chk("t4_done0", done[0], 3);
    // completion counting and underflow error
    resp.valid = 1'b1; resp.cmd.cu_id = 4'd2;
    step(5);
    chk("t5_done2", done[2], 5);
    chk("t5_outstanding", outstanding_count_out, 10);
    resp.cmd.cu_id = 4'd1;
    step(10);
    chk("t5_empty", outstanding_count_out, 0);
    chk("t5_no_error", error_out, 0);
    resp.cmd.cu_id = 4'd3;
    step(1);
    resp.valid = 1'b0;
    chk("t5_underflow_error", error_out, 1);
    chk("t5_floor", outstanding_count_out, 0);
    step(3);
    chk("t5_sticky", error_out, 1);
    // drain with three in flight
    rstn = 1'b1;
    step(1);
    chk("t6_err_clear", error_out, 0);
    rstn = 1'b0;
    step(1);
    request_in = 4'b0001;
    step(3);
    chk("t6_outstanding", outstanding_count_out, 3);
    enabled_in = 1'b0;
    step(1);
    chk("t6_drain_grant", grant_out, 0);
    chk("t6_drain_idle", idle_out, 0);
    step(1);
    chk("t6_drain_grant2", grant_out, 0);
    resp.valid = 1'b1; resp.cmd.cu_id = 4'd5;
    step(1);
    chk("t6_bad_id_error", error_out, 1);
    chk("t6_bad_id_retire", outstanding_count_out, 2);
    resp.cmd.cu_id = 4'd0;
    step(2);
    resp.valid = 1'b0; request_in = '0;
    chk("t6_drained", outstanding_count_out, 0);
    chk("t6_still_drain", idle_out, 0);
    step(1);
    chk("t6_idle", idle_out, 1);
    chk("t6_done0", done[0], 2);
    // reset while arbitrating
    enabled_in = 1'b1; request_in = 4'b1111;
    step(4);
    rstn = 1'b1;
    step(1);
    chk("t7_grant", grant_out, 0);
    chk("t7_cmd_valid", write_command_out.valid, 0);
    chk("t7_outstanding", outstanding_count_out, 0);
    chk("t7_idle", idle_out, 1);
    rstn = 1'b0; request_in = '0; enabled_in = 1'b0;
    resp.valid = 1'b1; resp.cmd.cu_id = 4'd1;
    step(1);
    resp.valid = 1'b0;
    chk("t7_stale_response", error_out, 1);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
